// File: rtl/detector_pkg.sv
// Shared field indices, sizing constants and reader state encoding for the
// keypad-entry to classifier path.
package detector_pkg;

  localparam int NUM_FIELDS = 7;
  localparam int DIGITS     = 4;
  localparam int VAL_W      = 14;

  localparam logic [2:0] FIELD_PREGNANCIES   = 3'd0;
  localparam logic [2:0] FIELD_GLUCOSE       = 3'd1;
  localparam logic [2:0] FIELD_BLOODPRESSURE = 3'd2;
  localparam logic [2:0] FIELD_SKINTHICKNESS = 3'd3;
  localparam logic [2:0] FIELD_INSULIN       = 3'd4;
  localparam logic [2:0] FIELD_BMI           = 3'd5;
  localparam logic [2:0] FIELD_AGE           = 3'd6;
  localparam logic [2:0] FIELD_OUTCOME       = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } reader_state_e;

endpackage

// File: rtl/bcd_mac10.sv
// One MSD-first decimal step: res = acc*10 + d, combinational.
// Non-BCD digits (>9) are clamped to 9 and flagged on err.
module bcd_mac10
  import detector_pkg::*;
(
  input  logic [VAL_W-1:0] acc,
  input  logic [3:0]       bcd,
  output logic [VAL_W-1:0] res,
  output logic             err
);

  logic [3:0]       d;
  logic [VAL_W-1:0] acc10;

  always_comb begin
    err   = (bcd > 4'd9);
    d     = err ? 4'd9 : bcd;
    acc10 = (acc << 3) + (acc << 1);
    res   = acc10 + {{(VAL_W-4){1'b0}}, d};
  end

endmodule

// File: rtl/field_bcd_reader.sv
// Reads 7 BCD fields from the digit store, converts each in 4 cycles and emits
// (field, value) pairs; out_valid holds the pair until out_ready, stalling the sequence.
module field_bcd_reader
  import detector_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  output logic [2:0]       rd_field,
  output logic [1:0]       rd_digit,
  input  logic [3:0]       rd_bcd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_field,
  output logic [VAL_W-1:0] out_value,
  output logic             busy,
  output logic             done,
  output logic             bcd_err
);

  localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);
  localparam logic [1:0] MSD        = 2'(DIGITS - 1);

  reader_state_e    state_q, state_d;
  logic [2:0]       field_q, field_d;
  logic [1:0]       digit_q, digit_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_field_q, out_field_d;
  logic [VAL_W-1:0] out_value_q, out_value_d;
  logic             bcd_err_q, bcd_err_d;

  logic [VAL_W-1:0] mac_res;
  logic             mac_err;

  bcd_mac10 u_mac (
    .acc (acc_q),
    .bcd (rd_bcd),
    .res (mac_res),
    .err (mac_err)
  );

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    digit_d     = digit_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_field_d = out_field_q;
    out_value_d = out_value_q;
    bcd_err_d   = bcd_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          field_d   = 3'd0;
          digit_d   = MSD;
          acc_d     = '0;
          bcd_err_d = 1'b0;
          state_d   = CONV;
        end
      end
      CONV: begin
        if (mac_err) bcd_err_d = 1'b1;
        if (digit_q == 2'd0) begin
          out_value_d = mac_res;
          out_field_d = field_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = EMIT;
        end else begin
          acc_d   = mac_res;
          digit_d = digit_q - 2'd1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (field_q == LAST_FIELD) begin
            state_d = DONE;
          end else begin
            // Next field's conversion starts on the handshake edge: no bubble.
            field_d = field_q + 3'd1;
            digit_d = MSD;
            acc_d   = '0;
            state_d = CONV;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      field_q     <= 3'd0;
      digit_q     <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_field_q <= 3'd0;
      out_value_q <= '0;
      bcd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      digit_q     <= digit_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_field_q <= out_field_d;
      out_value_q <= out_value_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  assign rd_field  = field_q;
  assign rd_digit  = digit_q;
  assign out_valid = out_valid_q;
  assign out_field = out_field_q;
  assign out_value = out_value_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_field_bcd_reader.sv
// Directed bench for field_bcd_reader: a behavioural digit store plus
// hand-computed expected pairs, timing and flag behaviour.
module tb_field_bcd_reader;

  logic        clk;
  logic        clear;
  logic        start;
  logic [2:0]  rd_field;
  logic [1:0]  rd_digit;
  logic [3:0]  rd_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_field;
  logic [13:0] out_value;
  logic        busy;
  logic        done;
  logic        bcd_err;

  logic [3:0]  mem [0:7][0:3];
  logic [16:0] pairs [$];
  int          done_cnt;
  int          checks;
  int          failures;

  int          exp_t1 [0:6] = '{3, 148, 72, 35, 0, 33, 50};
  int          exp_t3 [0:6] = '{0, 0, 90, 0, 0, 0, 0};

  field_bcd_reader dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .rd_field  (rd_field),
    .rd_digit  (rd_digit),
    .rd_bcd    (rd_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_value (out_value),
    .busy      (busy),
    .done      (done),
    .bcd_err   (bcd_err)
  );

  assign rd_bcd = mem[rd_field][rd_digit];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!clear && out_valid && out_ready) pairs.push_back({out_field, out_value});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int f, input int dec);
    int v;
    v = dec;
    for (int i = 0; i < 4; i++) begin
      mem[f][i] = 4'(v % 10);
      v = v / 10;
    end
  endtask

  task automatic load_set(input int sel);
    for (int f = 0; f < 8; f++) load(f, 0);
    if (sel == 1) for (int f = 0; f < 7; f++) load(f, exp_t1[f]);
    if (sel == 3) mem[2][1] = 4'hC;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_pairs(input string tag, input int sel);
    check({tag, "_count"}, pairs.size(), 32'd7);
    for (int k = 0; k < 7 && k < pairs.size(); k++) begin
      check({tag, "_field"}, {29'd0, pairs[k][16:14]}, k);
      check({tag, "_value"}, {18'd0, pairs[k][13:0]}, (sel == 1) ? exp_t1[k] : exp_t3[k]);
    end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    clear = 1'b1; start = 1'b0; out_ready = 1'b0;
    load_set(0);
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_field", {29'd0, out_field}, 0);
    check("rst_value", {18'd0, out_value}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, bcd_err}, 0);
    check("rst_rdf", {29'd0, rd_field}, 0);
    check("rst_rdd", {30'd0, rd_digit}, 0);
    clear = 1'b0;
    tick();

    // Full sequence with out_ready high, cycle-exact.
    load_set(1);
    out_ready = 1'b1;
    pulse_start();
    check("t1_busy0", {31'd0, busy}, 1);
    for (int n = 1; n <= 37; n++) begin
      logic ev;
      tick();
      ev = (n >= 4 && n <= 34 && ((n - 4) % 5) == 0);
      check("t1_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) begin
        check("t1_field", {29'd0, out_field}, (n - 4) / 5);
        check("t1_value", {18'd0, out_value}, exp_t1[(n - 4) / 5]);
      end
      check("t1_done", {31'd0, done}, (n == 35) ? 1 : 0);
      check("t1_busy", {31'd0, busy}, (n <= 35) ? 1 : 0);
    end

    // Backpressure: field 0 = 9999 held under out_ready low.
    load(0, 9999);
    out_ready = 1'b0;
    pulse_start();
    for (int n = 1; n <= 3; n++) tick();
    for (int n = 4; n <= 13; n++) begin
      tick();
      check("t2_hold_valid", {31'd0, out_valid}, 1);
      check("t2_hold_field", {29'd0, out_field}, 0);
      check("t2_hold_value", {18'd0, out_value}, 9999);
    end
    out_ready = 1'b1;
    tick();
    check("t2_acc_valid", {31'd0, out_valid}, 0);
    check("t2_acc_rdf", {29'd0, rd_field}, 1);
    check("t2_acc_rdd", {30'd0, rd_digit}, 3);
    tick();
    check("t2_conv_rdd", {30'd0, rd_digit}, 2);
    wait_done(60);
    tick(); tick();
    check("t2_idle_busy", {31'd0, busy}, 0);

    // Non-BCD digit clamps to 9 and sets the sticky error.
    load_set(3);
    pairs.delete();
    pulse_start();
    check("t3_err_cleared", {31'd0, bcd_err}, 0);
    wait_done(60);
    check("t3_err_set", {31'd0, bcd_err}, 1);
    tick(); tick(); tick();
    check("t3_err_sticky", {31'd0, bcd_err}, 1);
    check_pairs("t3", 3);

    // Clear during field 3 conversion aborts; a fresh start replays everything.
    pulse_start();
    check("t4_err_restart", {31'd0, bcd_err}, 0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 14) check("t4_err_f2", {31'd0, bcd_err}, 1);
    end
    check("t4_rdf_before", {29'd0, rd_field}, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_clr_valid", {31'd0, out_valid}, 0);
    check("t4_clr_busy", {31'd0, busy}, 0);
    check("t4_clr_err", {31'd0, bcd_err}, 0);
    check("t4_clr_done", {31'd0, done}, 0);
    check("t4_clr_rdf", {29'd0, rd_field}, 0);
    load_set(1);
    pairs.delete();
    pulse_start();
    wait_done(60);
    tick(); tick();
    check_pairs("t4", 1);

    // Second start while busy is ignored.
    pairs.delete();
    done_cnt = 0;
    pulse_start();
    for (int n = 1; n <= 11; n++) tick();
    pulse_start();
    wait_done(60);
    for (int n = 0; n < 6; n++) tick();
    check_pairs("t5", 1);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_idle_busy", {31'd0, busy}, 0);

    // Clear beats start on the same edge.
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_valid", {31'd0, out_valid}, 0);
    tick(); tick();
    check("t6_busy_later", {31'd0, busy}, 0);
    check("t6_rdd", {30'd0, rd_digit}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
